// File: rtl/cc_seq_ctrl.sv
// rtl/cc_seq_ctrl.sv - four-digit load / multi-pass CC run / four-digit unload sequencer
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_valid/in_ready      input beat handshake; in_digit carries n0..n3 in order
//   in_prog, in_len        op program (2 bits per pass) and pass count minus 1, taken on beat 0
//   cc_n0..cc_n3, cc_opt   working digits and op select driven to the external CC datapath
//   cc_o0..cc_o3           CC combinational results, written back once per RUN cycle
//   out_valid/out_ready    output beat handshake; out_digit carries w0..w3 in order
//   out_err                set on every output beat of a job that saw an out-of-range digit
//   busy                   high whenever the sequencer is not idle
module cc_seq_ctrl #(
  parameter int DIGIT_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_digit,
  input  logic [7:0] in_prog,
  input  logic [1:0] in_len,
  output logic [3:0] cc_n0,
  output logic [3:0] cc_n1,
  output logic [3:0] cc_n2,
  output logic [3:0] cc_n3,
  output logic [1:0] cc_opt,
  input  logic [3:0] cc_o0,
  input  logic [3:0] cc_o1,
  input  logic [3:0] cc_o2,
  input  logic [3:0] cc_o3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       busy
);

  localparam logic [3:0] LP_MAX = 4'(DIGIT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_beat;
  logic [1:0] r_pass;
  logic [1:0] r_len;
  logic [7:0] r_prog;
  logic [3:0] r_w [4];
  logic       r_err;

  logic       w_big;
  logic [3:0] w_sat;

  assign w_big = (in_digit > LP_MAX);
  assign w_sat = w_big ? LP_MAX : in_digit;

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        // A gap in the input stream abandons the job.
        if (!in_valid)          w_state_nxt = S_IDLE;
        else if (r_beat == 2'd3) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_pass == r_len) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready && (r_beat == 2'd3)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Working registers, counters and captured job parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= 2'd0;
      r_pass <= 2'd0;
      r_len  <= 2'd0;
      r_prog <= 8'd0;
      r_err  <= 1'b0;
      for (int i = 0; i < 4; i++) r_w[i] <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_w[0] <= w_sat;
            r_prog <= in_prog;
            r_len  <= in_len;
            r_err  <= w_big;
            r_beat <= 2'd1;
          end
        end
        S_LOAD: begin
          if (!in_valid) begin
            r_beat <= 2'd0;
            r_err  <= 1'b0;
            for (int i = 0; i < 4; i++) r_w[i] <= 4'd0;
          end else begin
            r_w[r_beat] <= w_sat;
            r_err       <= r_err | w_big;
            r_beat      <= r_beat + 2'd1;  // wraps to 0 after beat 3
            if (r_beat == 2'd3) r_pass <= 2'd0;
          end
        end
        S_RUN: begin
          r_w[0] <= cc_o0;
          r_w[1] <= cc_o1;
          r_w[2] <= cc_o2;
          r_w[3] <= cc_o3;
          r_pass <= r_pass + 2'd1;
          if (r_pass == r_len) r_beat <= 2'd0;
        end
        S_OUT: begin
          if (out_ready) r_beat <= r_beat + 2'd1;
        end
        default: r_beat <= 2'd0;
      endcase
    end
  end

  assign cc_n0 = r_w[0];
  assign cc_n1 = r_w[1];
  assign cc_n2 = r_w[2];
  assign cc_n3 = r_w[3];

  always_comb begin
    cc_opt = 2'd0;
    case (r_pass)
      2'd0: cc_opt = r_prog[1:0];
      2'd1: cc_opt = r_prog[3:2];
      2'd2: cc_opt = r_prog[5:4];
      2'd3: cc_opt = r_prog[7:6];
      default: cc_opt = 2'd0;
    endcase
  end

  // Result outputs are forced to zero outside OUT so nothing stale leaks.
  assign out_digit = out_valid ? r_w[r_beat] : 4'd0;
  assign out_err   = out_valid & r_err;

endmodule

// File: tb/tb_cc_seq_ctrl.sv
// tb/tb_cc_seq_ctrl.sv - directed table-driven bench for cc_seq_ctrl
module tb_cc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_digit = 4'd0;
  logic [7:0] in_prog = 8'd0;
  logic [1:0] in_len = 2'd0;
  logic [3:0] cc_n0, cc_n1, cc_n2, cc_n3;
  logic [1:0] cc_opt;
  logic [3:0] cc_o0, cc_o1, cc_o2, cc_o3;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_digit;
  logic       out_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  cc_seq_ctrl #(.DIGIT_MAX(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .in_prog(in_prog), .in_len(in_len),
    .cc_n0(cc_n0), .cc_n1(cc_n1), .cc_n2(cc_n2), .cc_n3(cc_n3), .cc_opt(cc_opt),
    .cc_o0(cc_o0), .cc_o1(cc_o1), .cc_o2(cc_o2), .cc_o3(cc_o3),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external CC datapath: the known transformations, rotate-left otherwise.
  // Digit vectors are packed n0 in the top nibble.
  function automatic logic [15:0] cc_model(input logic [1:0] op, input logic [15:0] n);
    logic [17:0] key;
    key = {op, n};
    case (key)
      {2'd0, 16'h3715}: return 16'h1354;
      {2'd1, 16'h1354}: return 16'h0234;
      {2'd2, 16'h3715}: return 16'h0628;
      {2'd3, 16'h3715}: return 16'h7695;
      {2'd1, 16'h9000}: return 16'h0009;
      default:          return {n[11:0], n[15:12]};
    endcase
  endfunction

  always_comb begin
    {cc_o0, cc_o1, cc_o2, cc_o3} = cc_model(cc_opt, {cc_n0, cc_n1, cc_n2, cc_n3});
  end

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [7:0]      prog;
    logic [1:0]      len;
    logic [3:0][3:0] e;
    logic            err;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input logic [15:0] d, input logic [7:0] p, input logic [1:0] l,
                              input logic [15:0] e, input logic er);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.d[i] = d[15-4*i -: 4];
      v.e[i] = e[15-4*i -: 4];
    end
    v.prog = p;
    v.len  = l;
    v.err  = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},  32'(in_ready), 32'd1);
    chk({tag, " busy"},      32'(busy), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_digit"}, 32'(out_digit), 32'd0);
    chk({tag, " out_err"},   32'(out_err), 32'd0);
    chk({tag, " cc_n"},      32'({cc_n0, cc_n1, cc_n2, cc_n3}), 32'd0);
    chk({tag, " cc_opt"},    32'(cc_opt), 32'd0);
  endtask

  // Loads one job (corrupting in_prog/in_len after beat 0), checks latency and the
  // four result beats; stall >= 0 holds out_ready low for 5 cycles on that beat.
  task automatic run_job(input int idx, input int stall);
    vec_t v;
    int   lat;
    v = tbl[idx];
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_digit = v.d[b];
      in_prog  = (b == 0) ? v.prog : ~v.prog;
      in_len   = (b == 0) ? v.len  : ~v.len;
      step();
    end
    in_valid = 1'b0;
    in_digit = 4'd0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk($sformatf("job%0d latency", idx), 32'(lat), 32'(v.len) + 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == stall) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk($sformatf("job%0d hold%0d digit", idx, s), 32'(out_digit), 32'(v.e[k]));
          chk($sformatf("job%0d hold%0d valid", idx, s), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("job%0d beat%0d digit", idx, k), 32'(out_digit), 32'(v.e[k]));
      chk($sformatf("job%0d beat%0d err", idx, k), 32'(out_err), 32'(v.err));
      chk($sformatf("job%0d beat%0d valid", idx, k), 32'(out_valid), 32'd1);
      step();
    end
    chk($sformatf("job%0d idle busy", idx), 32'(busy), 32'd0);
    chk($sformatf("job%0d idle valid", idx), 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    tbl[0] = mk(16'h3715, 8'h00, 2'd0, 16'h1354, 1'b0);
    tbl[1] = mk(16'h3715, 8'h04, 2'd1, 16'h0234, 1'b0);
    tbl[2] = mk(16'h3715, 8'h02, 2'd0, 16'h0628, 1'b0);
    tbl[3] = mk(16'h3715, 8'h03, 2'd0, 16'h7695, 1'b0);
    tbl[4] = mk(16'hC000, 8'h01, 2'd0, 16'h0009, 1'b1);
    tbl[5] = mk(16'h1234, 8'h55, 2'd3, 16'h1234, 1'b0);

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    for (int i = 0; i < 6; i++) run_job(i, -1);

    // Abort: two beats then a gap.
    in_valid = 1'b1; in_digit = 4'd3; in_prog = 8'h00; in_len = 2'd0;
    step();
    in_digit = 4'd7;
    step();
    in_valid = 1'b0;
    step();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      step();
    end
    chk("abort no output", 32'(seen), 32'd0);
    run_job(0, -1);

    // Backpressure on beat 2 of a two-pass job.
    run_job(1, 2);

    // Reset in the middle of a four-pass RUN.
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_digit = tbl[5].d[b];
      in_prog  = tbl[5].prog;
      in_len   = tbl[5].len;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("runreset");
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen++;
      step();
    end
    chk("runreset no output", 32'(seen), 32'd0);
    run_job(3, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
